// File: rtl/regfile_param_if.sv
// Register file port bundle: two read ports, one write port and the clear handshake.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read1;
  logic [ADDR_W-1:0] read2;
  logic [ADDR_W-1:0] reg_write;
  logic [DATA_W-1:0] wdata;
  logic              write;
  logic              clear_req;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              busy;
  logic              clear_done;

  modport master (
    output read1, read2, reg_write, wdata, write, clear_req,
    input  data1, data2, busy, clear_done
  );

  modport slave (
    input  read1, read2, reg_write, wdata, write, clear_req,
    output data1, data2, busy, clear_done
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised MIPS register file with async reset and a sequenced hardware clear.
// Define REGFILE_BYPASS_EN to forward the pending write onto matching read ports.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  regfile_param_if.slave   bus
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NUM_RD = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             cnt;
  logic [DEPTH-1:0][DATA_W-1:0]  mem;
  logic                          busy_q;
  logic                          done_q;
  logic                          wr_en;

  // Register 0 is not a legal write target when it is hardwired to zero.
  assign wr_en = bus.write && !busy_q &&
                 !((ZERO_REG != 0) && (bus.reg_write == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident write lands before the clear starts walking.
          if (wr_en) mem[bus.reg_write] <= bus.wdata;
          if (bus.clear_req) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (cnt == ADDR_W'(DEPTH-1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  assign raddr = {bus.read2, bus.read1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic fwd;
`ifdef REGFILE_BYPASS_EN
    assign fwd = wr_en && (bus.reg_write == raddr[p]);
`else
    assign fwd = 1'b0;
`endif
    assign rdata[p] = ((ZERO_REG != 0) && (raddr[p] == '0)) ? '0 :
                      fwd ? bus.wdata : mem[raddr[p]];
  end

  assign bus.data1      = rdata[0];
  assign bus.data2      = rdata[1];
  assign bus.busy       = busy_q;
  assign bus.clear_done = done_q;
endmodule

// File: tb/tb_regfile_param.sv
// Directed + randomized bench for regfile_param; drives a ZERO_REG=1 and a ZERO_REG=0 copy in lockstep.
module tb_regfile_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] read1 = '0, read2 = '0, reg_write = '0;
  logic [DW-1:0] wdata = '0;
  logic          write = 1'b0, clear_req = 1'b0;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

  assign b0.read1 = read1;  assign b1.read1 = read1;
  assign b0.read2 = read2;  assign b1.read2 = read2;
  assign b0.reg_write = reg_write;  assign b1.reg_write = reg_write;
  assign b0.wdata = wdata;  assign b1.wdata = wdata;
  assign b0.write = write;  assign b1.write = write;
  assign b0.clear_req = clear_req;  assign b1.clear_req = clear_req;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Reference model: plain arrays plus "edges left in the clear walk".
  logic [DW-1:0] m [2][D];
  int            clr_left = 0;
  logic          exp_done = 1'b0;
  int            npass = 0, ntot = 0;

  task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
    if (k == 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write && clr_left == 0 && !(k == 0 && reg_write == 0) && reg_write == a) return wdata;
`endif
    return m[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) for (int i = 0; i < D; i++) m[k][i] = '0;
    clr_left = 0;
    exp_done = 1'b0;
  endtask

  task automatic model_edge();
    if (clr_left > 0) begin
      m[0][D-clr_left] = '0;
      m[1][D-clr_left] = '0;
      exp_done = (clr_left == 1);
      clr_left--;
    end else begin
      exp_done = 1'b0;
      if (write) begin
        if (reg_write != 0) m[0][reg_write] = wdata;
        m[1][reg_write] = wdata;
      end
      if (clear_req) clr_left = D;
    end
  endtask

  task automatic chk(input string ph);
    cmp({ph, " z1.data1"}, b0.data1, exp_rd(0, read1));
    cmp({ph, " z1.data2"}, b0.data2, exp_rd(0, read2));
    cmp({ph, " z0.data1"}, b1.data1, exp_rd(1, read1));
    cmp({ph, " z0.data2"}, b1.data2, exp_rd(1, read2));
    cmp({ph, " z1.busy"}, DW'(b0.busy), DW'(clr_left > 0));
    cmp({ph, " z0.busy"}, DW'(b1.busy), DW'(clr_left > 0));
    cmp({ph, " z1.done"}, DW'(b0.clear_done), DW'(exp_done));
    cmp({ph, " z0.done"}, DW'(b1.clear_done), DW'(exp_done));
  endtask

  // Called just after a rising edge: settle, check, advance one edge, check again.
  task automatic tick();
    #2 chk("pre");
    model_edge();
    @(posedge clk);
    #1 chk("post");
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1'b1; reg_write = a; wdata = d;
    tick();
    write = 1'b0;
  endtask

  initial begin
    int n;
    // Reset asserted mid-cycle, then sweep every address.
    #3 rst = 1'b1;
    model_reset();
    for (int i = 0; i < D; i++) begin
      read1 = AW'(i); read2 = AW'(D-1-i);
      #1 chk("reset");
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic write/read, idle cycles hold contents.
    read1 = 5'd3; read2 = 5'd8;
    wr(5'd8, 32'h0000000F);
    cmp("r8_read", b0.data2, 32'h0000000F);
    wr(5'd3, 32'h00000007);
    cmp("r3_read", b0.data1, 32'h00000007);
    tick(); tick();
    cmp("r8_hold", b0.data2, 32'h0000000F);

    // Register 0 behaviour differs by ZERO_REG.
    read1 = 5'd0;
    wr(5'd0, 32'hDEADBEEF);
    cmp("r0_zero", b0.data1, 32'h0);
    cmp("r0_plain", b1.data1, 32'hDEADBEEF);

    // Bypass visibility before the write edge.
    read1 = 5'd5;
    wr(5'd5, 32'h00000001);
    write = 1'b1; reg_write = 5'd5; wdata = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    cmp("bypass_pre", b0.data1, 32'h12345678);
`else
    cmp("bypass_pre", b0.data1, 32'h00000001);
`endif
    tick();
    write = 1'b0;
    cmp("bypass_post", b0.data1, 32'h12345678);

    // Fill and run a full clear.
    for (int i = 1; i < D; i++) wr(AW'(i), DW'(32'h100 + i));
    read1 = 5'd4; read2 = 5'd7;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (b0.busy && n < 40) begin
      n++;
      if (n == 10) begin write = 1'b1; reg_write = 5'd7; wdata = 32'hCAFE0007; end
      else write = 1'b0;
      tick();
      cmp("r4_during_clear", b0.data1, (n < 5) ? 32'h104 : 32'h0);
    end
    cmp("busy_len", DW'(n), 32'd32);
    cmp("done_pulse", DW'(b0.clear_done), 32'd1);
    read1 = 5'd9;
    wr(5'd9, 32'h00000999);
    cmp("done_cycle_write", b0.data1, 32'h00000999);
    cmp("done_single", DW'(b0.clear_done), 32'd0);
    cmp("r7_dropped", b0.data2, 32'h0);

    // Reset mid-clear aborts without clear_done, next clear runs full length.
    for (int i = 1; i < D; i++) wr(AW'(i), DW'(32'h200 + i));
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #3 rst = 1'b1;
    model_reset();
    #1 chk("midclear_rst");
    cmp("rst_busy_async", DW'(b0.busy), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1 chk("after_rst");
    cmp("no_done_after_abort", DW'(b0.clear_done), 32'd0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (b0.busy && n < 40) begin n++; tick(); end
    cmp("busy_len2", DW'(n), 32'd32);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      write     = 1'($urandom_range(0, 1));
      reg_write = AW'($urandom);
      wdata     = $urandom;
      read1     = AW'($urandom);
      read2     = ($urandom_range(0, 3) == 0) ? reg_write : AW'($urandom);
      clear_req = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
